// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//   Multi-cycle controller sitting between the instruction decoder and the
//   8-bit ALU datapath. One operation is accepted per valid/ready handshake and
//   is walked through LOAD (operands steered onto the ALU buses) and EXEC (one
//   ALU op enable asserted). The ALU outputs are captured at the end of EXEC,
//   and the result and N/Z/C/V flags are published in DONE.
//
// Ports
//   clk, nrst                 clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake (ready in IDLE or DONE)
//   req_op/req_a/req_b        opcode and operands, latched on accept
//   flag_c_in, decimal_flag   current C and D flags, latched on accept
//   sb_bus/db_bus/adl_bus     ALU operand buses
//   ldb_*/lda_*               ALU operand selects
//   e_*                       ALU op enables (EXEC only)
//   enable_dec, carry_in      ALU decimal mode and carry in
//   alu_out/alu_carry/alu_ovf ALU results, sampled at the end of EXEC
//   result, flag_n/z/c/v      registered result and flags
//   page_cross                registered carry of the last ADDR op
//   done                      one-cycle pulse, result/flags valid
//   err_illegal               one-cycle pulse, illegal opcode rejected
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter bit DEC_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       flag_c_in,
    input  logic       decimal_flag,
    output logic [7:0] sb_bus,
    output logic [7:0] db_bus,
    output logic [7:0] adl_bus,
    output logic       ldb_inv_db,
    output logic       ldb_db,
    output logic       ldb_adl,
    output logic       lda_sb,
    output logic       lda_zero,
    output logic       e_sum,
    output logic       e_and,
    output logic       e_eor,
    output logic       e_or,
    output logic       e_shiftr,
    output logic       enable_dec,
    output logic       carry_in,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    input  logic       alu_ovf,
    output logic [7:0] result,
    output logic       flag_n,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_v,
    output logic       page_cross,
    output logic       done,
    output logic       err_illegal
);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

    localparam logic [3:0] OP_ADC  = 4'h0;
    localparam logic [3:0] OP_SBC  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_ORA  = 4'h3;
    localparam logic [3:0] OP_EOR  = 4'h4;
    localparam logic [3:0] OP_LSR  = 4'h5;
    localparam logic [3:0] OP_ROR  = 4'h6;
    localparam logic [3:0] OP_ASL  = 4'h7;
    localparam logic [3:0] OP_ROL  = 4'h8;
    localparam logic [3:0] OP_INC  = 4'h9;
    localparam logic [3:0] OP_DEC  = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_ADDR = 4'hC;

    state_t     state, state_next;
    logic [3:0] op_q;
    logic [7:0] a_q, b_q;
    logic       c_q, d_q;
    logic       err_q;
    logic       accept, legal, drive, in_exec, dec_mode;

    assign req_ready   = (state == IDLE) || (state == DONE);
    assign accept      = req_valid && req_ready;
    assign legal       = (req_op <= OP_ADDR);
    assign drive       = (state == LOAD) || (state == EXEC);
    assign in_exec     = (state == EXEC);
    assign done        = (state == DONE);
    assign err_illegal = err_q;

    // Decimal mode only ever applies to ADC/SBC, and only when built in.
    assign dec_mode = DEC_ENABLE && d_q && ((op_q == OP_ADC) || (op_q == OP_SBC));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = accept ? (legal ? LOAD : IDLE) : IDLE;
            LOAD:       state_next = EXEC;
            EXEC:       state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Request latch, illegal-op pulse and result/flag capture.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            op_q       <= 4'h0;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            c_q        <= 1'b0;
            d_q        <= 1'b0;
            err_q      <= 1'b0;
            result     <= 8'h00;
            flag_n     <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_v     <= 1'b0;
            page_cross <= 1'b0;
        end else begin
            err_q <= accept && !legal;
            if (accept) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
                c_q  <= flag_c_in;
                d_q  <= decimal_flag;
            end
            if (state == EXEC) begin
                case (op_q)
                    OP_ADC, OP_SBC: begin
                        result <= alu_out;
                        flag_n <= alu_out[7];
                        flag_z <= (alu_out == 8'h00);
                        flag_c <= alu_carry;
                        flag_v <= alu_ovf;
                    end
                    OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC: begin
                        result <= alu_out;
                        flag_n <= alu_out[7];
                        flag_z <= (alu_out == 8'h00);
                    end
                    OP_LSR, OP_ROR, OP_ASL, OP_ROL: begin
                        result <= alu_out;
                        flag_n <= alu_out[7];
                        flag_z <= (alu_out == 8'h00);
                        flag_c <= alu_carry;
                    end
                    OP_CMP: begin
                        // Compare only sets flags; the previous result stays.
                        flag_n <= alu_out[7];
                        flag_z <= (alu_out == 8'h00);
                        flag_c <= alu_carry;
                    end
                    OP_ADDR: begin
                        result     <= alu_out;
                        page_cross <= alu_carry;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ALU steering: buses/selects in LOAD and EXEC, the op enable in EXEC only.
    always_comb begin
        sb_bus     = 8'h00;
        db_bus     = 8'h00;
        adl_bus    = 8'h00;
        ldb_inv_db = 1'b0;
        ldb_db     = 1'b0;
        ldb_adl    = 1'b0;
        lda_sb     = 1'b0;
        lda_zero   = 1'b0;
        e_sum      = 1'b0;
        e_and      = 1'b0;
        e_eor      = 1'b0;
        e_or       = 1'b0;
        e_shiftr   = 1'b0;
        enable_dec = 1'b0;
        carry_in   = 1'b0;
        if (drive) begin
            lda_sb = 1'b1;
            sb_bus = a_q;
            case (op_q)
                OP_ADC: begin
                    db_bus     = b_q;
                    ldb_db     = 1'b1;
                    e_sum      = in_exec;
                    enable_dec = dec_mode;
                    carry_in   = dec_mode ? 1'b0 : c_q;
                end
                OP_SBC: begin
                    // Decimal subtract feeds B uninverted; the ALU does the subtract.
                    db_bus     = b_q;
                    ldb_db     = dec_mode;
                    ldb_inv_db = !dec_mode;
                    e_sum      = in_exec;
                    enable_dec = dec_mode;
                    carry_in   = dec_mode ? 1'b1 : c_q;
                end
                OP_AND: begin db_bus = b_q; ldb_db = 1'b1; e_and = in_exec; end
                OP_ORA: begin db_bus = b_q; ldb_db = 1'b1; e_or  = in_exec; end
                OP_EOR: begin db_bus = b_q; ldb_db = 1'b1; e_eor = in_exec; end
                OP_LSR: begin e_shiftr = in_exec; end
                OP_ROR: begin e_shiftr = in_exec; carry_in = c_q; end
                // Left shifts are A + A through the adder.
                OP_ASL: begin db_bus = a_q; ldb_db = 1'b1; e_sum = in_exec; end
                OP_ROL: begin db_bus = a_q; ldb_db = 1'b1; e_sum = in_exec; carry_in = c_q; end
                OP_INC: begin db_bus = 8'h00; ldb_db = 1'b1; e_sum = in_exec; carry_in = 1'b1; end
                OP_DEC: begin db_bus = 8'hFF; ldb_db = 1'b1; e_sum = in_exec; end
                OP_CMP: begin db_bus = b_q; ldb_inv_db = 1'b1; e_sum = in_exec; carry_in = 1'b1; end
                OP_ADDR: begin adl_bus = b_q; ldb_adl = 1'b1; e_sum = in_exec; end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Drives alu_op_sequencer with directed and random operations. A behavioural
//   ALU answers the DUT's bus/select outputs; expected results come from the
//   arithmetic meaning of each opcode. A second instance is built without
//   decimal support.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int CLK_P = 10;

    typedef struct packed {
        logic [7:0] sb, db, adl;
        logic ldb_inv_db, ldb_db, ldb_adl, lda_sb, lda_zero;
        logic e_sum, e_and, e_eor, e_or, e_shiftr;
        logic enable_dec, carry_in, done, err_illegal, req_ready;
    } ctrl_t;

    typedef struct packed {
        logic [7:0] result;
        logic n, z, c, v, pc;
    } st_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic req_valid = 1'b0;
    logic [3:0] req_op = 4'h0;
    logic [7:0] req_a = 8'h00, req_b = 8'h00;
    logic flag_c_in = 1'b0, decimal_flag = 1'b0;

    logic req_ready, ldb_inv_db, ldb_db, ldb_adl, lda_sb, lda_zero;
    logic e_sum, e_and, e_eor, e_or, e_shiftr, enable_dec, carry_in;
    logic [7:0] sb_bus, db_bus, adl_bus, alu_out, result;
    logic alu_carry, alu_ovf, flag_n, flag_z, flag_c, flag_v, page_cross, done, err_illegal;

    logic req_ready0, ldb_inv_db0, ldb_db0, ldb_adl0, lda_sb0, lda_zero0;
    logic e_sum0, e_and0, e_eor0, e_or0, e_shiftr0, enable_dec0, carry_in0;
    logic [7:0] sb_bus0, db_bus0, adl_bus0, alu_out0, result0;
    logic alu_carry0, alu_ovf0, flag_n0, flag_z0, flag_c0, flag_v0, page_cross0, done0, err_illegal0;

    int checks = 0;
    int errors = 0;
    st_t m_st = '0;

    always #(CLK_P/2) clk = ~clk;

    alu_op_sequencer #(.DEC_ENABLE(1'b1)) dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .flag_c_in(flag_c_in),
        .decimal_flag(decimal_flag), .sb_bus(sb_bus), .db_bus(db_bus), .adl_bus(adl_bus),
        .ldb_inv_db(ldb_inv_db), .ldb_db(ldb_db), .ldb_adl(ldb_adl), .lda_sb(lda_sb),
        .lda_zero(lda_zero), .e_sum(e_sum), .e_and(e_and), .e_eor(e_eor), .e_or(e_or),
        .e_shiftr(e_shiftr), .enable_dec(enable_dec), .carry_in(carry_in),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_ovf(alu_ovf), .result(result),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .page_cross(page_cross), .done(done), .err_illegal(err_illegal)
    );

    alu_op_sequencer #(.DEC_ENABLE(1'b0)) dut0 (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready0),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .flag_c_in(flag_c_in),
        .decimal_flag(decimal_flag), .sb_bus(sb_bus0), .db_bus(db_bus0), .adl_bus(adl_bus0),
        .ldb_inv_db(ldb_inv_db0), .ldb_db(ldb_db0), .ldb_adl(ldb_adl0), .lda_sb(lda_sb0),
        .lda_zero(lda_zero0), .e_sum(e_sum0), .e_and(e_and0), .e_eor(e_eor0), .e_or(e_or0),
        .e_shiftr(e_shiftr0), .enable_dec(enable_dec0), .carry_in(carry_in0),
        .alu_out(alu_out0), .alu_carry(alu_carry0), .alu_ovf(alu_ovf0), .result(result0),
        .flag_n(flag_n0), .flag_z(flag_z0), .flag_c(flag_c0), .flag_v(flag_v0),
        .page_cross(page_cross0), .done(done0), .err_illegal(err_illegal0)
    );

    function automatic int bcd2i(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    // Behavioural ALU: {ovf, carry, out} from the steering the DUT presents.
    function automatic logic [9:0] alu_fn(input logic [7:0] sb, db, adl,
                                          input logic inv, ldb, ladl, lsb,
                                          input logic es, ea, ee, eo, esr, ed, ci);
        logic [7:0] a, b, o;
        logic [8:0] t;
        logic co, vo;
        int ia;
        a = lsb ? sb : 8'h00;
        b = ldb ? db : (inv ? ~db : (ladl ? adl : 8'h00));
        o = 8'h00; co = 1'b0; vo = 1'b0;
        if (es && ed) begin
            if (!ci) begin
                ia = bcd2i(a) + bcd2i(b); co = (ia >= 100); o = i2bcd(ia % 100);
            end else begin
                ia = bcd2i(a) - bcd2i(b); co = (ia >= 0); o = i2bcd(ia < 0 ? ia + 100 : ia);
            end
        end else if (es) begin
            t = {1'b0, a} + {1'b0, b} + {8'h00, ci};
            o = t[7:0]; co = t[8]; vo = (a[7] == b[7]) && (o[7] != a[7]);
        end else if (ea) o = a & b;
        else if (eo) o = a | b;
        else if (ee) o = a ^ b;
        else if (esr) begin o = {ci, a[7:1]}; co = a[0]; end
        return {vo, co, o};
    endfunction

    assign {alu_ovf, alu_carry, alu_out} = alu_fn(sb_bus, db_bus, adl_bus, ldb_inv_db, ldb_db,
        ldb_adl, lda_sb, e_sum, e_and, e_eor, e_or, e_shiftr, enable_dec, carry_in);
    assign {alu_ovf0, alu_carry0, alu_out0} = alu_fn(sb_bus0, db_bus0, adl_bus0, ldb_inv_db0,
        ldb_db0, ldb_adl0, lda_sb0, e_sum0, e_and0, e_eor0, e_or0, e_shiftr0, enable_dec0, carry_in0);

    // Architectural effect of one operation on result/flags.
    function automatic st_t model_op(input st_t s, input logic [3:0] op, input logic [7:0] a, b,
                                     input logic c, d, input bit dec_en);
        logic [8:0] t;
        logic [7:0] r;
        logic cf, vf;
        bit dec, u_res, u_nz, u_c, u_v, u_pc;
        int ia;
        dec = dec_en && d && (op <= 4'h1);
        r = 8'h00; cf = 1'b0; vf = 1'b0;
        {u_res, u_nz, u_c, u_v, u_pc} = 5'b0;
        case (op)
            4'h0: begin
                {u_res, u_nz, u_c, u_v} = 4'hF;
                if (dec) begin ia = bcd2i(a) + bcd2i(b); cf = (ia >= 100); r = i2bcd(ia % 100); end
                else begin t = a + b + c; r = t[7:0]; cf = t[8]; vf = (a[7] == b[7]) && (r[7] != a[7]); end
            end
            4'h1: begin
                {u_res, u_nz, u_c, u_v} = 4'hF;
                if (dec) begin
                    ia = bcd2i(a) - bcd2i(b); cf = (ia >= 0); r = i2bcd(ia < 0 ? ia + 100 : ia);
                end else begin
                    t = {1'b0, a} + {1'b0, ~b} + {8'h00, c}; r = t[7:0]; cf = t[8];
                    vf = (a[7] != b[7]) && (r[7] != a[7]);
                end
            end
            4'h2: begin r = a & b; {u_res, u_nz} = 2'b11; end
            4'h3: begin r = a | b; {u_res, u_nz} = 2'b11; end
            4'h4: begin r = a ^ b; {u_res, u_nz} = 2'b11; end
            4'h5: begin r = a >> 1; cf = a[0]; {u_res, u_nz, u_c} = 3'b111; end
            4'h6: begin r = {c, a[7:1]}; cf = a[0]; {u_res, u_nz, u_c} = 3'b111; end
            4'h7: begin r = {a[6:0], 1'b0}; cf = a[7]; {u_res, u_nz, u_c} = 3'b111; end
            4'h8: begin r = {a[6:0], c}; cf = a[7]; {u_res, u_nz, u_c} = 3'b111; end
            4'h9: begin r = a + 8'h01; {u_res, u_nz} = 2'b11; end
            4'hA: begin r = a - 8'h01; {u_res, u_nz} = 2'b11; end
            4'hB: begin r = a - b; cf = (a >= b); {u_nz, u_c} = 2'b11; end
            4'hC: begin t = a + b; r = t[7:0]; cf = t[8]; {u_res, u_pc} = 2'b11; end
            default: ;
        endcase
        if (u_res) s.result = r;
        if (u_nz) begin s.n = r[7]; s.z = (r == 8'h00); end
        if (u_c) s.c = cf;
        if (u_v) s.v = vf;
        if (u_pc) s.pc = cf;
        return s;
    endfunction

    // Expected ALU controls: phase 0 LOAD, 1 EXEC, 2 DONE, 3 IDLE.
    function automatic ctrl_t exp_ctrl(input logic [3:0] op, input logic [7:0] a, b,
                                       input logic c, d, input int phase);
        ctrl_t x;
        bit dec, ex;
        x = '0;
        dec = d && (op <= 4'h1);
        ex = (phase == 1);
        if (phase >= 2) begin
            x.done = (phase == 2);
            x.req_ready = 1'b1;
            return x;
        end
        x.lda_sb = 1'b1; x.sb = a;
        case (op)
            4'h0: begin x.db = b; x.ldb_db = 1; x.e_sum = ex; x.enable_dec = dec; x.carry_in = dec ? 1'b0 : c; end
            4'h1: begin
                x.db = b; x.ldb_db = dec; x.ldb_inv_db = !dec; x.e_sum = ex;
                x.enable_dec = dec; x.carry_in = dec ? 1'b1 : c;
            end
            4'h2: begin x.db = b; x.ldb_db = 1; x.e_and = ex; end
            4'h3: begin x.db = b; x.ldb_db = 1; x.e_or = ex; end
            4'h4: begin x.db = b; x.ldb_db = 1; x.e_eor = ex; end
            4'h5: begin x.e_shiftr = ex; end
            4'h6: begin x.e_shiftr = ex; x.carry_in = c; end
            4'h7: begin x.db = a; x.ldb_db = 1; x.e_sum = ex; end
            4'h8: begin x.db = a; x.ldb_db = 1; x.e_sum = ex; x.carry_in = c; end
            4'h9: begin x.db = 8'h00; x.ldb_db = 1; x.e_sum = ex; x.carry_in = 1; end
            4'hA: begin x.db = 8'hFF; x.ldb_db = 1; x.e_sum = ex; end
            4'hB: begin x.db = b; x.ldb_inv_db = 1; x.e_sum = ex; x.carry_in = 1; end
            4'hC: begin x.adl = b; x.ldb_adl = 1; x.e_sum = ex; end
            default: ;
        endcase
        return x;
    endfunction

    function automatic ctrl_t snap();
        return {sb_bus, db_bus, adl_bus, ldb_inv_db, ldb_db, ldb_adl, lda_sb, lda_zero,
                e_sum, e_and, e_eor, e_or, e_shiftr, enable_dec, carry_in, done, err_illegal, req_ready};
    endfunction

    function automatic st_t snap_st();
        return {result, flag_n, flag_z, flag_c, flag_v, page_cross};
    endfunction

    // Issue one op starting at a negedge; returns at the DONE-cycle negedge.
    // With scramble, req_valid stays high with junk while the DUT is busy.
    task automatic step_op(input logic [3:0] op, input logic [7:0] a, b, input logic c, d,
                           input bit scramble, output ctrl_t o_load, o_exec, o_done, output st_t s_done);
        int w = 0;
        while (!req_ready && w < 8) begin @(negedge clk); w++; end
        checks++;
        if (!req_ready) begin errors++; $display("FAIL ready_wait req_ready=%b required 1", req_ready); end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; flag_c_in = c; decimal_flag = d;
        @(negedge clk);
        o_load = snap();
        if (scramble) begin
            req_op = 4'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
            flag_c_in = ~c; decimal_flag = ~d;
        end else req_valid = 1'b0;
        @(negedge clk);
        o_exec = snap();
        req_valid = 1'b0;
        @(negedge clk);
        o_done = snap();
        s_done = snap_st();
    endtask

    task automatic test_reset();
        ctrl_t x;
        #3;
        x = exp_ctrl(4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 3);
        checks++;
        if (snap() !== x) begin errors++; $display("FAIL reset_ctrl got %h required %h", snap(), x); end
        checks++;
        if (snap_st() !== st_t'(0)) begin errors++; $display("FAIL reset_state got %h required 0", snap_st()); end
        @(negedge clk); nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_adc_binary();
        ctrl_t l, e, d; st_t s;
        step_op(4'h0, 8'h45, 8'h2A, 1'b0, 1'b0, 1'b0, l, e, d, s);
        m_st = model_op(m_st, 4'h0, 8'h45, 8'h2A, 1'b0, 1'b0, 1'b1);
        checks++;
        if (l !== exp_ctrl(4'h0, 8'h45, 8'h2A, 0, 0, 0)) begin errors++; $display("FAIL adc_load got %h required %h", l, exp_ctrl(4'h0, 8'h45, 8'h2A, 0, 0, 0)); end
        checks++;
        if (e !== exp_ctrl(4'h0, 8'h45, 8'h2A, 0, 0, 1)) begin errors++; $display("FAIL adc_exec got %h required %h", e, exp_ctrl(4'h0, 8'h45, 8'h2A, 0, 0, 1)); end
        checks++;
        if (d !== exp_ctrl(4'h0, 8'h45, 8'h2A, 0, 0, 2)) begin errors++; $display("FAIL adc_done got %h required %h", d, exp_ctrl(4'h0, 8'h45, 8'h2A, 0, 0, 2)); end
        checks++;
        if (s !== m_st || s.result !== 8'h6F || {s.n, s.z, s.c} !== 3'b000) begin errors++; $display("FAIL adc_result got %h required %h", s, m_st); end
    endtask

    task automatic test_decimal();
        ctrl_t l, e, d; st_t s;
        step_op(4'h0, 8'h09, 8'h01, 1'b0, 1'b1, 1'b0, l, e, d, s);
        m_st = model_op(m_st, 4'h0, 8'h09, 8'h01, 1'b0, 1'b1, 1'b1);
        checks++;
        if (l !== exp_ctrl(4'h0, 8'h09, 8'h01, 0, 1, 0) || !l.enable_dec) begin errors++; $display("FAIL dec_load got %h required %h", l, exp_ctrl(4'h0, 8'h09, 8'h01, 0, 1, 0)); end
        checks++;
        if (e !== exp_ctrl(4'h0, 8'h09, 8'h01, 0, 1, 1)) begin errors++; $display("FAIL dec_exec got %h required %h", e, exp_ctrl(4'h0, 8'h09, 8'h01, 0, 1, 1)); end
        checks++;
        if (s !== m_st || s.result !== 8'h10 || s.c !== 1'b0) begin errors++; $display("FAIL dec_result got %h required %h", s, m_st); end
        checks++;
        if (result0 !== 8'h0A || flag_c0 !== 1'b0) begin errors++; $display("FAIL nodec_result got %h c=%b required 0a c=0", result0, flag_c0); end
        // Decimal SBC: 0x42 - 0x17 = 0x25, no borrow.
        step_op(4'h1, 8'h42, 8'h17, 1'b0, 1'b1, 1'b0, l, e, d, s);
        m_st = model_op(m_st, 4'h1, 8'h42, 8'h17, 1'b0, 1'b1, 1'b1);
        checks++;
        if (e !== exp_ctrl(4'h1, 8'h42, 8'h17, 0, 1, 1)) begin errors++; $display("FAIL dsbc_exec got %h required %h", e, exp_ctrl(4'h1, 8'h42, 8'h17, 0, 1, 1)); end
        checks++;
        if (s !== m_st || s.result !== 8'h25 || s.c !== 1'b1) begin errors++; $display("FAIL dsbc_result got %h required %h", s, m_st); end
    endtask

    task automatic test_cmp_preload();
        ctrl_t l, e, d; st_t s;
        step_op(4'h0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0, l, e, d, s);   // sets V
        m_st = model_op(m_st, 4'h0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b1);
        checks++;
        if (s !== m_st || s.v !== 1'b1) begin errors++; $display("FAIL ovf_setup got %h required %h", s, m_st); end
        step_op(4'h3, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, l, e, d, s);   // result = 0x55
        m_st = model_op(m_st, 4'h3, 8'h55, 8'h00, 1'b0, 1'b0, 1'b1);
        step_op(4'hB, 8'h30, 8'h30, 1'b0, 1'b0, 1'b0, l, e, d, s);
        m_st = model_op(m_st, 4'hB, 8'h30, 8'h30, 1'b0, 1'b0, 1'b1);
        checks++;
        if (e !== exp_ctrl(4'hB, 8'h30, 8'h30, 0, 0, 1)) begin errors++; $display("FAIL cmp_exec got %h required %h", e, exp_ctrl(4'hB, 8'h30, 8'h30, 0, 0, 1)); end
        checks++;
        if (s !== m_st || s.result !== 8'h55 || {s.n, s.z, s.c, s.v} !== 4'b0111) begin errors++; $display("FAIL cmp_flags got %h required %h", s, m_st); end
    endtask

    task automatic test_back_to_back();
        ctrl_t l, e, d; st_t s;
        longint t1, t2;
        step_op(4'h5, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, l, e, d, s);
        m_st = model_op(m_st, 4'h5, 8'h81, 8'h00, 1'b0, 1'b0, 1'b1);
        t1 = $time;
        checks++;
        if (s !== m_st || s.result !== 8'h40 || s.c !== 1'b1) begin errors++; $display("FAIL lsr_result got %h required %h", s, m_st); end
        step_op(4'h6, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, l, e, d, s);
        m_st = model_op(m_st, 4'h6, 8'h02, 8'h00, 1'b1, 1'b0, 1'b1);
        t2 = $time;
        checks++;
        if (s !== m_st || s.result !== 8'h81 || {s.n, s.c} !== 2'b10) begin errors++; $display("FAIL ror_result got %h required %h", s, m_st); end
        checks++;
        if (!d.done || (t2 - t1) != 3 * CLK_P) begin errors++; $display("FAIL b2b_spacing got %0d required %0d", t2 - t1, 3 * CLK_P); end
        checks++;
        if (l !== exp_ctrl(4'h6, 8'h02, 8'h00, 1, 0, 0)) begin errors++; $display("FAIL ror_load got %h required %h", l, exp_ctrl(4'h6, 8'h02, 8'h00, 1, 0, 0)); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        ctrl_t l, e, d, x; st_t s;
        req_valid = 1'b1; req_op = 4'hE; req_a = 8'hFF; req_b = 8'hFF;
        @(negedge clk);
        req_valid = 1'b0;
        x = exp_ctrl(4'hE, 8'h00, 8'h00, 0, 0, 3); x.err_illegal = 1'b1;
        checks++;
        if (snap() !== x) begin errors++; $display("FAIL illegal_pulse got %h required %h", snap(), x); end
        @(negedge clk);
        x.err_illegal = 1'b0;
        checks++;
        if (snap() !== x || snap_st() !== m_st) begin errors++; $display("FAIL illegal_after got %h/%h required %h/%h", snap(), snap_st(), x, m_st); end
        // Illegal op accepted straight out of DONE.
        step_op(4'h9, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, l, e, d, s);
        m_st = model_op(m_st, 4'h9, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (s !== m_st || s.result !== 8'h80 || s.n !== 1'b1) begin errors++; $display("FAIL inc_result got %h required %h", s, m_st); end
        req_valid = 1'b1; req_op = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        x.err_illegal = 1'b1;
        checks++;
        if (snap() !== x || snap_st() !== m_st) begin errors++; $display("FAIL illegal_in_done got %h/%h required %h/%h", snap(), snap_st(), x, m_st); end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        ctrl_t l, e, d; st_t s;
        step_op(4'hC, 8'hF0, 8'h20, 1'b0, 1'b0, 1'b1, l, e, d, s);
        m_st = model_op(m_st, 4'hC, 8'hF0, 8'h20, 1'b0, 1'b0, 1'b1);
        checks++;
        if (e !== exp_ctrl(4'hC, 8'hF0, 8'h20, 0, 0, 1)) begin errors++; $display("FAIL busy_exec got %h required %h", e, exp_ctrl(4'hC, 8'hF0, 8'h20, 0, 0, 1)); end
        checks++;
        if (s !== m_st || s.result !== 8'h10 || s.pc !== 1'b1) begin errors++; $display("FAIL addr_result got %h required %h", s, m_st); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        ctrl_t l, e, d, x; st_t s;
        int dn = 0;
        req_valid = 1'b1; req_op = 4'h0; req_a = 8'h12; req_b = 8'h34; flag_c_in = 1'b1; decimal_flag = 1'b0;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (e_sum !== 1'b1) begin errors++; $display("FAIL mid_exec e_sum=%b required 1", e_sum); end
        #2 nrst = 1'b0;
        #1;
        m_st = '0;
        x = exp_ctrl(4'h0, 8'h00, 8'h00, 0, 0, 3);
        checks++;
        if (snap() !== x || snap_st() !== m_st) begin errors++; $display("FAIL mid_reset got %h/%h required %h/0", snap(), snap_st(), x); end
        @(negedge clk); @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (done) dn++; end
        checks++;
        if (dn != 0) begin errors++; $display("FAIL mid_no_done got %0d pulses required 0", dn); end
        step_op(4'h7, 8'hC1, 8'h00, 1'b0, 1'b0, 1'b0, l, e, d, s);
        m_st = model_op(m_st, 4'h7, 8'hC1, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (s !== m_st || s.result !== 8'h82 || s.c !== 1'b1) begin errors++; $display("FAIL post_reset got %h required %h", s, m_st); end
        @(negedge clk);
    endtask

    task automatic test_random();
        ctrl_t l, e, d; st_t s;
        logic [3:0] op; logic [7:0] a, b; logic c, dd; bit scr;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 12));
            a = 8'($urandom); b = 8'($urandom);
            c = 1'($urandom); dd = 1'($urandom);
            if (dd && op <= 4'h1) begin
                a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            scr = ($urandom_range(0, 3) == 0);
            step_op(op, a, b, c, dd, scr, l, e, d, s);
            m_st = model_op(m_st, op, a, b, c, dd, 1'b1);
            checks++;
            if (l !== exp_ctrl(op, a, b, c, dd, 0)) begin errors++; $display("FAIL rnd_load op=%h got %h required %h", op, l, exp_ctrl(op, a, b, c, dd, 0)); end
            checks++;
            if (e !== exp_ctrl(op, a, b, c, dd, 1)) begin errors++; $display("FAIL rnd_exec op=%h got %h required %h", op, e, exp_ctrl(op, a, b, c, dd, 1)); end
            checks++;
            if (d !== exp_ctrl(op, a, b, c, dd, 2)) begin errors++; $display("FAIL rnd_done op=%h got %h required %h", op, d, exp_ctrl(op, a, b, c, dd, 2)); end
            checks++;
            if (s !== m_st) begin errors++; $display("FAIL rnd_state op=%h a=%h b=%h got %h required %h", op, a, b, s, m_st); end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_adc_binary();
        test_decimal();
        test_cmp_preload();
        test_back_to_back();
        test_illegal();
        test_ignore_busy();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(CLK_P * 20000);
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
